// File: rtl/park_dq_transform.sv
// Clarke + Park transform (abc -> dq) in IEEE-754 single precision, sharing one
// pipelined adder and one pipelined multiplier under a counter-sequenced FSM.
module park_dq_transform #(
  parameter int          ADD_LAT   = 7,
  parameter int          MUL_LAT   = 5,
  parameter logic [31:0] INV_3     = 32'h3EAAAAAB,
  parameter logic [31:0] INV_SQRT3 = 32'h3F13CD3A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sta,
  input  logic [31:0] Va,
  input  logic [31:0] Vb,
  input  logic [31:0] Vc,
  input  logic [31:0] sin,
  input  logic [31:0] cos,
  output logic [31:0] d,
  output logic [31:0] q,
  output logic        busy,
  output logic        done_sig
);

  typedef enum logic [2:0] {IDLE, ADD1, ADD2, MUL1, MUL2, ADD3, DONE} state_t;

  localparam logic [7:0] A_K = 8'(ADD_LAT);
  localparam logic [7:0] M_K = 8'(MUL_LAT);

  function automatic logic [31:0] fp_neg(input logic [31:0] v);
    return {~v[31], v[30:0]};
  endfunction

  // 2*v by exponent increment; zero/denormal collapse to signed zero, top exponent saturates
  function automatic logic [31:0] fp_twice(input logic [31:0] v);
    logic [31:0] r;
    if (v[30:23] == 8'd0) r = {v[31], 31'd0};
    else if (v[30:23] == 8'd254) r = {v[31], 8'hFF, 23'd0};
    else if (v[30:23] == 8'd255) r = v;
    else r = {v[31], v[30:23] + 8'd1, v[22:0]};
    return r;
  endfunction

  function automatic logic [31:0] fp_add_f(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic [7:0]  ex, ey, sh;
    logic [26:0] mx, my, mys;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] rnd;
    logic        rup;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex  = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey  = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx  = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    my  = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    sh  = ex - ey;
    if (sh >= 8'd27) mys = {26'd0, |my};
    else mys = (my >> sh) | {26'd0, |(my & ((27'd1 << sh) - 27'd1))};
    if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, mys};
    else s = {1'b0, mx} - {1'b0, mys};
    e = {2'b00, ex};
    if (x[30:23] == 8'hFF) res = x;
    else if (s == 28'd0) res = {x[31] & y[31], 31'd0};
    else begin
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'd1;
      end else begin
        // normalise left, stopping at the denormal exponent
        for (int i = 0; i < 26; i++) begin
          if (!s[26] && e > 10'd1) begin
            s = s << 1;
            e = e - 10'd1;
          end
        end
      end
      rup = s[2] & (s[1] | s[0] | s[3]);
      rnd = {1'b0, s[26:3]} + {24'd0, rup};
      if (rnd[24]) begin
        rnd = rnd >> 1;
        e = e + 10'd1;
      end
      if (e >= 10'd255) res = {x[31], 8'hFF, 23'd0};
      else res = {x[31], (rnd[23] ? e[7:0] : 8'd0), rnd[22:0]};
    end
    return res;
  endfunction

  // Denormal operands and underflowing products flush to signed zero
  function automatic logic [31:0] fp_mul_f(input logic [31:0] a, input logic [31:0] b);
    logic              sgn, g, st;
    logic [47:0]       p;
    logic [23:0]       m;
    logic [24:0]       rnd;
    logic signed [10:0] e;
    logic [31:0]       res;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) res = {sgn, 8'hFF, 23'd0};
    else if (a[30:23] == 8'd0 || b[30:23] == 8'd0) res = {sgn, 31'd0};
    else begin
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
      if (p[47]) begin
        m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 11'sd1;
      end else begin
        m = p[46:23]; g = p[22]; st = |p[21:0];
      end
      rnd = {1'b0, m} + {24'd0, g & (st | m[0])};
      if (rnd[24]) begin
        rnd = rnd >> 1;
        e = e + 11'sd1;
      end
      if (e >= 11'sd255) res = {sgn, 8'hFF, 23'd0};
      else if (e <= 11'sd0 || !rnd[23]) res = {sgn, 31'd0};
      else res = {sgn, e[7:0], rnd[22:0]};
    end
    return res;
  endfunction

  state_t      state_r, state_nx_s;
  logic [7:0]  cnt_r, cnt_nx_s;
  logic [31:0] va2_r, vb_r, vc_r, sin_r, cos_r;
  logic [31:0] sum_r, diff_r, apre_r, alpha_r, beta_r;
  logic [31:0] ac_r, bs_r, asn_r, bc_r;
  logic [31:0] add_a_r, add_b_r, mul_a_r, mul_b_r;
  logic [31:0] d_r, q_r;
  logic        busy_r, done_r;
  logic [31:0] add_res_s, mul_res_s, add_out_s, mul_out_s;
  logic [31:0] add_pipe_r [ADD_LAT-1];
  logic [31:0] mul_pipe_r [MUL_LAT-1];

  assign add_res_s = fp_add_f(add_a_r, add_b_r);
  assign mul_res_s = fp_mul_f(mul_a_r, mul_b_r);
  assign add_out_s = add_pipe_r[ADD_LAT-2];
  assign mul_out_s = mul_pipe_r[MUL_LAT-2];

  // Arithmetic pipelines: operand registers plus LAT-1 result stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ADD_LAT - 1; i++) add_pipe_r[i] <= 32'd0;
      for (int i = 0; i < MUL_LAT - 1; i++) mul_pipe_r[i] <= 32'd0;
    end else begin
      add_pipe_r[0] <= add_res_s;
      mul_pipe_r[0] <= mul_res_s;
      for (int i = 1; i < ADD_LAT - 1; i++) add_pipe_r[i] <= add_pipe_r[i-1];
      for (int i = 1; i < MUL_LAT - 1; i++) mul_pipe_r[i] <= mul_pipe_r[i-1];
    end
  end

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next state: each phase counts down from its wait length
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (sta) begin state_nx_s = ADD1; cnt_nx_s = A_K + 8'd1; end
        else begin state_nx_s = IDLE; cnt_nx_s = 8'd0; end
      end
      ADD1: begin
        if (cnt_r == 8'd0) begin state_nx_s = ADD2; cnt_nx_s = A_K; end
        else begin cnt_nx_s = cnt_r - 8'd1; end
      end
      ADD2: begin
        if (cnt_r == 8'd0) begin state_nx_s = MUL1; cnt_nx_s = M_K + 8'd1; end
        else begin cnt_nx_s = cnt_r - 8'd1; end
      end
      MUL1: begin
        if (cnt_r == 8'd0) begin state_nx_s = MUL2; cnt_nx_s = M_K + 8'd1; end
        else begin cnt_nx_s = cnt_r - 8'd1; end
      end
      MUL2: begin
        if (cnt_r == 8'd0) begin state_nx_s = ADD3; cnt_nx_s = A_K + 8'd2; end
        else begin cnt_nx_s = cnt_r - 8'd1; end
      end
      ADD3: begin
        if (cnt_r == 8'd0) begin state_nx_s = DONE; cnt_nx_s = 8'd0; end
        else begin cnt_nx_s = cnt_r - 8'd1; end
      end
      DONE: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 8'd0;
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 8'd0;
      end
    endcase
  end

  // Datapath: operand issue, intermediate capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {va2_r, vb_r, vc_r, sin_r, cos_r}         <= {5{32'd0}};
      {sum_r, diff_r, apre_r, alpha_r, beta_r}  <= {5{32'd0}};
      {ac_r, bs_r, asn_r, bc_r}                 <= {4{32'd0}};
      {add_a_r, add_b_r, mul_a_r, mul_b_r}      <= {4{32'd0}};
      d_r    <= 32'd0;
      q_r    <= 32'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sta) begin
            va2_r  <= fp_twice(Va);
            vb_r   <= Vb;
            vc_r   <= Vc;
            sin_r  <= sin;
            cos_r  <= cos;
            busy_r <= 1'b1;
          end
        end
        ADD1: begin
          if (cnt_r == A_K + 8'd1) begin add_a_r <= vb_r; add_b_r <= vc_r; end
          if (cnt_r == A_K) begin add_a_r <= vb_r; add_b_r <= fp_neg(vc_r); end
          if (cnt_r == 8'd1) sum_r <= add_out_s;
          if (cnt_r == 8'd0) diff_r <= add_out_s;
        end
        ADD2: begin
          if (cnt_r == A_K) begin add_a_r <= va2_r; add_b_r <= fp_neg(sum_r); end
          if (cnt_r == 8'd0) apre_r <= add_out_s;
        end
        MUL1: begin
          if (cnt_r == M_K + 8'd1) begin mul_a_r <= apre_r; mul_b_r <= INV_3; end
          if (cnt_r == M_K) begin mul_a_r <= diff_r; mul_b_r <= INV_SQRT3; end
          if (cnt_r == 8'd1) alpha_r <= mul_out_s;
          if (cnt_r == 8'd0) beta_r <= mul_out_s;
        end
        MUL2: begin
          if (cnt_r == M_K + 8'd1) begin mul_a_r <= alpha_r; mul_b_r <= cos_r; end
          if (cnt_r == M_K) begin mul_a_r <= beta_r; mul_b_r <= sin_r; end
          if (cnt_r == M_K - 8'd1) begin mul_a_r <= alpha_r; mul_b_r <= sin_r; end
          if (cnt_r == M_K - 8'd2) begin mul_a_r <= beta_r; mul_b_r <= cos_r; end
          if (cnt_r == 8'd1) ac_r <= mul_out_s;
          if (cnt_r == 8'd0) bs_r <= mul_out_s;
        end
        ADD3: begin
          // the last two products land while the d sum is already in flight
          if (cnt_r == A_K + 8'd2) begin
            add_a_r <= ac_r;
            add_b_r <= bs_r;
            asn_r   <= mul_out_s;
          end
          if (cnt_r == A_K + 8'd1) bc_r <= mul_out_s;
          if (cnt_r == A_K) begin add_a_r <= bc_r; add_b_r <= fp_neg(asn_r); end
          if (cnt_r == 8'd2) d_r <= add_out_s;
          if (cnt_r == 8'd0) begin
            q_r    <= add_out_s;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign d        = d_r;
  assign q        = q_r;
  assign busy     = busy_r;
  assign done_sig = done_r;

endmodule

// File: tb/tb_park_dq_transform.sv
// Self-checking bench for park_dq_transform: directed cases, handshake and
// reset behaviour, plus random vectors against a real-valued reference.
module tb_park_dq_transform;

  logic        clk, rst_n, sta;
  logic [31:0] Va, Vb, Vc, sin, cos;
  logic [31:0] d, q;
  logic        busy, done_sig;

  int n_cmp = 0;
  int n_err = 0;

  park_dq_transform dut (
    .clk(clk), .rst_n(rst_n), .sta(sta),
    .Va(Va), .Vb(Vb), .Vc(Vc), .sin(sin), .cos(cos),
    .d(d), .q(q), .busy(busy), .done_sig(done_sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real b2r(input logic [31:0] b);
    real v;
    if (b[30:23] == 8'd0) v = real'(b[22:0]) * pow2(-149);
    else v = (real'(b[22:0]) + 8388608.0) * pow2(int'(b[30:23]) - 150);
    return b[31] ? -v : v;
  endfunction

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  function automatic logic [31:0] rand_f(input int emin, input int emax);
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(emax, emin));
    return r;
  endfunction

  function automatic bit ulp_near(input logic [31:0] obs, input logic [31:0] exp, input int n);
    int diff;
    if (obs[31] != exp[31]) return 1'b0;
    diff = int'({1'b0, obs[30:0]}) - int'({1'b0, exp[30:0]});
    return (diff <= n) && (diff >= -n);
  endfunction

  // Reference: exact transform, tolerance scaled by the operand magnitudes
  function automatic bit model_ok(input logic [31:0] a, b, c, s, co,
                                  input logic [31:0] od, oq);
    real alpha, beta, md, mq, scale, tol;
    alpha = (2.0 * b2r(a) - (b2r(b) + b2r(c))) / 3.0;
    beta  = (b2r(b) - b2r(c)) / $sqrt(3.0);
    md    = alpha * b2r(co) + beta * b2r(s);
    mq    = beta * b2r(co) - alpha * b2r(s);
    scale = (2.0 * rabs(b2r(a)) + rabs(b2r(b)) + rabs(b2r(c))) * (rabs(b2r(s)) + rabs(b2r(co)));
    tol   = 4.0e-6 * scale + 1.0e-30;
    return (rabs(b2r(od) - md) <= tol) && (rabs(b2r(oq) - mq) <= tol);
  endfunction

  task automatic scramble();
    Va = $urandom; Vb = $urandom; Vc = $urandom; sin = $urandom; cos = $urandom;
  endtask

  task automatic do_run(input logic [31:0] a, b, c, s, co,
                        output int lat, output logic [31:0] od, output logic [31:0] oq);
    int hi_cnt;
    Va = a; Vb = b; Vc = c; sin = s; cos = co; sta = 1'b1;
    tick();
    sta = 1'b0;
    scramble();
    lat = -1; od = 32'd0; oq = 32'd0; hi_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      if (busy) hi_cnt++;
      if (done_sig) begin
        lat = i; od = d; oq = q;
        break;
      end
      tick();
    end
    chk("busy_span", 32'(hi_cnt), 32'd42);
    tick();
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done_sig), 32'd0);
  endtask

  initial begin
    int lat, pulses, busy_hi;
    int done_q[$];
    logic [31:0] od, oq, ra, rb, rc, rs, rco, od2, oq2;

    rst_n = 1'b0; sta = 1'b0;
    Va = 32'd0; Vb = 32'd0; Vc = 32'd0; sin = 32'd0; cos = 32'd0;
    repeat (3) tick();
    chk("rst_d", d, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_sig), 32'd0);
    rst_n = 1'b1;

    pulses = 0; busy_hi = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_sig) pulses++;
      if (busy) busy_hi++;
      tick();
    end
    chk("idle_done", 32'(pulses), 32'd0);
    chk("idle_busy", 32'(busy_hi), 32'd0);
    chk("idle_d", d, 32'd0);
    chk("idle_q", q, 32'd0);

    // aligned: alpha = 1, beta = 0
    do_run(32'h3F800000, 32'hBF000000, 32'hBF000000, 32'h00000000, 32'h3F800000, lat, od, oq);
    chk("aligned_lat", 32'(lat), 32'd42);
    chk("aligned_d", 32'(ulp_near(od, 32'h3F800000, 2)), 32'd1);
    chk("aligned_q_zero", {1'b0, oq[30:0]}, 32'd0);

    do_run(32'h3F800000, 32'hBF000000, 32'hBF000000, 32'h3F800000, 32'h00000000, lat, od, oq);
    chk("quad_lat", 32'(lat), 32'd42);
    chk("quad_d_zero", {1'b0, od[30:0]}, 32'd0);
    chk("quad_q", 32'(ulp_near(oq, 32'hBF800000, 2)), 32'd1);

    do_run(32'h00000000, 32'hBF5DB3D7, 32'h3F5DB3D7, 32'hBF800000, 32'h00000000, lat, od, oq);
    chk("beta_lat", 32'(lat), 32'd42);
    chk("beta_d", 32'(ulp_near(od, 32'h3F800000, 2)), 32'd1);
    chk("beta_q_small", 32'({1'b0, oq[30:0]} <= 32'd2), 32'd1);

    // handshake: sta at 0 accepted, 10 and 42 ignored, 43 accepted
    ra = rand_f(118, 134); rb = rand_f(118, 134); rc = rand_f(118, 134);
    rs = rand_f(110, 126); rco = rand_f(110, 126);
    Va = ra; Vb = rb; Vc = rc; sin = rs; cos = rco; sta = 1'b1;
    tick();
    sta = 1'b0;
    scramble();
    od = 32'd0; oq = 32'd0; od2 = 32'd0; oq2 = 32'd0;
    for (int i = 1; i <= 100; i++) begin
      sta = (i == 10 || i == 42 || i == 43);
      if (i == 43) begin
        Va = 32'h40400000; Vb = 32'hBF800000; Vc = 32'h3F000000;
        sin = 32'h3F000000; cos = 32'h3F5DB3D7;
      end else begin
        scramble();
      end
      if (done_sig) begin
        done_q.push_back(i);
        if (i == 42) begin od = d; oq = q; end
        if (i == 85) begin od2 = d; oq2 = q; end
      end
      tick();
    end
    sta = 1'b0;
    chk("hs_pulses", 32'(done_q.size()), 32'd2);
    chk("hs_first", 32'(done_q[0]), 32'd42);
    chk("hs_second", 32'(done_q[1]), 32'd85);
    chk("hs_first_val", 32'(model_ok(ra, rb, rc, rs, rco, od, oq)), 32'd1);
    chk("hs_second_val", 32'(model_ok(32'h40400000, 32'hBF800000, 32'h3F000000,
                                       32'h3F000000, 32'h3F5DB3D7, od2, oq2)), 32'd1);
    chk("hold_d", d, od2);
    chk("hold_q", q, oq2);

    // reset in the middle of a run
    Va = 32'h3F800000; Vb = 32'hBF000000; Vc = 32'hBF000000;
    sin = 32'h3F000000; cos = 32'h3F000000; sta = 1'b1;
    tick();
    sta = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_d", d, 32'd0);
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_sig) pulses++;
      tick();
    end
    chk("mid_rst_nodone", 32'(pulses), 32'd0);
    do_run(32'h3F800000, 32'hBF000000, 32'hBF000000, 32'h00000000, 32'h3F800000, lat, od, oq);
    chk("post_rst_lat", 32'(lat), 32'd42);
    chk("post_rst_d", 32'(ulp_near(od, 32'h3F800000, 2)), 32'd1);

    for (int k = 0; k < 16; k++) begin
      ra = rand_f(118, 134); rb = rand_f(118, 134); rc = rand_f(118, 134);
      rs = rand_f(110, 126); rco = rand_f(110, 126);
      do_run(ra, rb, rc, rs, rco, lat, od, oq);
      chk("rand_lat", 32'(lat), 32'd42);
      chk("rand_dq", 32'(model_ok(ra, rb, rc, rs, rco, od, oq)), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
